// File: rtl/fetch_stage.sv
// Fetch stage: PC register, single-outstanding instruction-memory sequencer
// and IF/ID pipeline register with stall/flush handling.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        hazard_ok_i,
   input  logic        flush_i,
   input  logic [31:0] branch_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_valid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] pc_o,
   output logic [31:0] if_id_instr_o,
   output logic [31:0] if_id_pc_o,
   output logic        if_id_valid_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FULL} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] buf_q, buf_d;
   logic        discard_q, discard_d;
   logic        deliver;
   logic [31:0] deliver_instr;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      buf_d         = buf_q;
      discard_d     = discard_q;
      deliver       = 1'b0;
      deliver_instr = buf_q;
      case (state_q)
         IDLE: begin
            if (start_i) state_d = ISSUE;
         end
         ISSUE: begin
            state_d = WAIT;
            if (flush_i) begin
               pc_d      = branch_target_i;
               discard_d = 1'b1;
            end
         end
         WAIT: begin
            if (!imem_valid_i) begin
               if (flush_i) begin
                  pc_d      = branch_target_i;
                  discard_d = 1'b1;
               end
            end else if (discard_q) begin
               // stale response from before a redirect; a flush here only moves pc
               discard_d = 1'b0;
               state_d   = ISSUE;
               if (flush_i) pc_d = branch_target_i;
            end else if (flush_i) begin
               pc_d    = branch_target_i;
               state_d = ISSUE;
            end else if (hazard_ok_i) begin
               deliver       = 1'b1;
               deliver_instr = imem_rdata_i;
               pc_d          = pc_q + 32'd4;
               state_d       = ISSUE;
            end else begin
               buf_d   = imem_rdata_i;
               state_d = FULL;
            end
         end
         FULL: begin
            if (flush_i) begin
               pc_d    = branch_target_i;
               state_d = ISSUE;
            end else if (hazard_ok_i) begin
               deliver       = 1'b1;
               deliver_instr = buf_q;
               pc_d          = pc_q + 32'd4;
               state_d       = ISSUE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         buf_q         <= '0;
         discard_q     <= 1'b0;
         if_id_instr_o <= NOP_INSTR;
         if_id_pc_o    <= '0;
         if_id_valid_o <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         buf_q     <= buf_d;
         discard_q <= discard_d;
         // flush beats stall; a free slot with nothing delivered becomes a bubble
         if (flush_i) begin
            if_id_instr_o <= NOP_INSTR;
            if_id_pc_o    <= '0;
            if_id_valid_o <= 1'b0;
         end else if (hazard_ok_i) begin
            if (deliver) begin
               if_id_instr_o <= deliver_instr;
               if_id_pc_o    <= pc_q;
               if_id_valid_o <= 1'b1;
            end else begin
               if_id_instr_o <= NOP_INSTR;
               if_id_pc_o    <= '0;
               if_id_valid_o <= 1'b0;
            end
         end
      end
   end

   assign imem_req_o  = (state_q == ISSUE);
   assign imem_addr_o = pc_q;
   assign pc_o        = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-programmable memory responder
// plus one task per scenario with hand-computed expectations.
module tb_fetch_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        hazard_ok_i;
   logic        flush_i;
   logic [31:0] branch_target_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_valid_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] pc_o;
   logic [31:0] if_id_instr_o;
   logic [31:0] if_id_pc_o;
   logic        if_id_valid_o;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   int unsigned mem_lat    = 1;
   bit          mem_manual = 1'b1;
   bit          man_valid  = 1'b0;
   logic [31:0] man_data   = '0;

   fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .hazard_ok_i(hazard_ok_i),
      .flush_i(flush_i), .branch_target_i(branch_target_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_valid_i(imem_valid_i), .imem_rdata_i(imem_rdata_i),
      .pc_o(pc_o), .if_id_instr_o(if_id_instr_o), .if_id_pc_o(if_id_pc_o),
      .if_id_valid_o(if_id_valid_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h0000_0011;
         32'h4:   return 32'h0000_0022;
         32'h8:   return 32'h0000_0033;
         default: return 32'hC000_0000 ^ a;
      endcase
   endfunction

   // Memory responder: a request seen at a negedge is answered mem_lat cycles later
   initial begin
      int unsigned cnt;
      logic [31:0] addr;
      cnt = 0; addr = '0;
      imem_valid_i = 1'b0; imem_rdata_i = '0;
      forever begin
         @(negedge clk_i);
         if (mem_manual) begin
            cnt = 0;
            imem_valid_i = man_valid;
            imem_rdata_i = man_data;
         end else begin
            imem_valid_i = 1'b0;
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  imem_valid_i = 1'b1;
                  imem_rdata_i = word_at(addr);
               end
            end
            if (imem_req_o) begin
               cnt  = mem_lat;
               addr = imem_addr_o;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (if_id_valid_o) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   // Reset two cycles, then start; returns at the negedge of the first ISSUE cycle
   task automatic restart(input int unsigned lat);
      rst_i = 1'b0; start_i = 1'b0; flush_i = 1'b0; hazard_ok_i = 1'b1;
      mem_manual = 1'b1; man_valid = 1'b0; mem_lat = lat;
      tick(); tick();
      rst_i = 1'b1; start_i = 1'b1; mem_manual = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      rst_i = 1'b0; start_i = 1'b0; flush_i = 1'b0; hazard_ok_i = 1'b1;
      branch_target_i = '0; mem_manual = 1'b1; man_valid = 1'b0; mem_lat = 1;
      tick(); tick();
      n_cmp++; if (pc_o !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h expected %h", pc_o, 32'h0); end
      n_cmp++; if (if_id_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", if_id_valid_o); end
      n_cmp++; if (if_id_instr_o !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h expected 0", if_id_instr_o); end
      n_cmp++; if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b expected 0", imem_req_o); end
      rst_i = 1'b1;
      tick();
      n_cmp++; if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL idle_req: got %b expected 0", imem_req_o); end
      n_cmp++; if (pc_o !== 32'h0) begin n_err++; $display("FAIL idle_pc: got %h expected 0", pc_o); end
      start_i = 1'b1; mem_manual = 1'b0;
      tick();
      n_cmp++; if (imem_req_o !== 1'b1) begin n_err++; $display("FAIL start_req: got %b expected 1", imem_req_o); end
      n_cmp++; if (imem_addr_o !== 32'h0) begin n_err++; $display("FAIL start_addr: got %h expected 0", imem_addr_o); end
   endtask

   task automatic test_straight_line;
      bit ok;
      for (int i = 0; i < 3; i++) begin
         wait_valid(ok);
         n_cmp++; if (!ok) begin n_err++; $display("FAIL line_timeout[%0d]: got no valid, expected valid", i); end
         n_cmp++; if (if_id_instr_o !== word_at(32'(4 * i))) begin n_err++; $display("FAIL line_instr[%0d]: got %h expected %h", i, if_id_instr_o, word_at(32'(4 * i))); end
         n_cmp++; if (if_id_pc_o !== 32'(4 * i)) begin n_err++; $display("FAIL line_ifpc[%0d]: got %h expected %h", i, if_id_pc_o, 32'(4 * i)); end
         n_cmp++; if (pc_o !== 32'(4 * i + 4)) begin n_err++; $display("FAIL line_pc[%0d]: got %h expected %h", i, pc_o, 32'(4 * i + 4)); end
         tick();
         n_cmp++; if (if_id_valid_o !== 1'b0) begin n_err++; $display("FAIL line_bubble[%0d]: got %b expected 0", i, if_id_valid_o); end
      end
   endtask

   task automatic test_stall;
      bit ok;
      restart(1);
      wait_valid(ok);
      n_cmp++; if (!ok || if_id_instr_o !== 32'h11) begin n_err++; $display("FAIL stall_first: got %h expected %h", if_id_instr_o, 32'h11); end
      hazard_ok_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (if_id_instr_o !== 32'h11 || if_id_valid_o !== 1'b1) begin n_err++; $display("FAIL stall_hold[%0d]: got %h/%b expected 00000011/1", i, if_id_instr_o, if_id_valid_o); end
         n_cmp++; if (pc_o !== 32'h4) begin n_err++; $display("FAIL stall_pc[%0d]: got %h expected 4", i, pc_o); end
      end
      n_cmp++; if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL stall_full_req: got %b expected 0", imem_req_o); end
      hazard_ok_i = 1'b1;
      tick();
      n_cmp++; if (if_id_instr_o !== 32'h22) begin n_err++; $display("FAIL stall_release_instr: got %h expected 22", if_id_instr_o); end
      n_cmp++; if (if_id_pc_o !== 32'h4) begin n_err++; $display("FAIL stall_release_ifpc: got %h expected 4", if_id_pc_o); end
      n_cmp++; if (pc_o !== 32'h8) begin n_err++; $display("FAIL stall_release_pc: got %h expected 8", pc_o); end
   endtask

   task automatic test_flush_wait;
      bit          got, seen_req;
      logic [31:0] first_addr;
      restart(3);
      tick();
      flush_i = 1'b1; branch_target_i = 32'h40;
      tick();
      flush_i = 1'b0;
      n_cmp++; if (pc_o !== 32'h40) begin n_err++; $display("FAIL flush_pc: got %h expected 40", pc_o); end
      n_cmp++; if (if_id_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b expected 0", if_id_valid_o); end
      got = 1'b0; seen_req = 1'b0; first_addr = 'x;
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         if (imem_req_o && !seen_req) begin seen_req = 1'b1; first_addr = imem_addr_o; end
         if (if_id_valid_o) got = 1'b1;
      end
      n_cmp++; if (!got) begin n_err++; $display("FAIL flush_timeout: got no valid, expected valid"); end
      n_cmp++; if (first_addr !== 32'h40) begin n_err++; $display("FAIL flush_req_addr: got %h expected 40", first_addr); end
      n_cmp++; if (if_id_pc_o !== 32'h40) begin n_err++; $display("FAIL flush_ifpc: got %h expected 40", if_id_pc_o); end
      n_cmp++; if (if_id_instr_o !== word_at(32'h40)) begin n_err++; $display("FAIL flush_instr: got %h expected %h", if_id_instr_o, word_at(32'h40)); end
   endtask

   task automatic test_flush_stall;
      bit ok;
      restart(1);
      wait_valid(ok);
      n_cmp++; if (!ok || if_id_instr_o !== 32'h11) begin n_err++; $display("FAIL fs_first: got %h expected 11", if_id_instr_o); end
      hazard_ok_i = 1'b0;
      tick(); tick();
      n_cmp++; if (pc_o !== 32'h4 || imem_req_o !== 1'b0) begin n_err++; $display("FAIL fs_full: got pc %h req %b expected pc 4 req 0", pc_o, imem_req_o); end
      flush_i = 1'b1; branch_target_i = 32'h80;
      tick();
      flush_i = 1'b0;
      n_cmp++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0 || if_id_pc_o !== 32'h0) begin n_err++; $display("FAIL fs_ifid: got %h/%h/%b expected 0/0/0", if_id_instr_o, if_id_pc_o, if_id_valid_o); end
      n_cmp++; if (pc_o !== 32'h80) begin n_err++; $display("FAIL fs_pc: got %h expected 80", pc_o); end
      n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h80) begin n_err++; $display("FAIL fs_req: got %b@%h expected 1@00000080", imem_req_o, imem_addr_o); end
      hazard_ok_i = 1'b1;
      wait_valid(ok);
      n_cmp++; if (!ok || if_id_instr_o !== word_at(32'h80) || if_id_pc_o !== 32'h80) begin n_err++; $display("FAIL fs_after: got %h@%h expected %h@00000080", if_id_instr_o, if_id_pc_o, word_at(32'h80)); end
   endtask

   task automatic test_reset_mid;
      bit ok;
      restart(3);
      tick();
      mem_manual = 1'b1; man_valid = 1'b1; man_data = 32'hDEAD_BEEF;
      rst_i = 1'b0;
      tick(); tick();
      n_cmp++; if (pc_o !== 32'h0 || imem_req_o !== 1'b0) begin n_err++; $display("FAIL rm_reset: got pc %h req %b expected 0/0", pc_o, imem_req_o); end
      n_cmp++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0) begin n_err++; $display("FAIL rm_ifid: got %h/%b expected 0/0", if_id_instr_o, if_id_valid_o); end
      rst_i = 1'b1; start_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (imem_req_o !== 1'b0 || if_id_valid_o !== 1'b0 || pc_o !== 32'h0) begin n_err++; $display("FAIL rm_idle[%0d]: got req %b valid %b pc %h expected 0/0/0", i, imem_req_o, if_id_valid_o, pc_o); end
      end
      man_valid = 1'b0; mem_manual = 1'b0; mem_lat = 1;
      start_i = 1'b1;
      tick();
      wait_valid(ok);
      n_cmp++; if (!ok || if_id_instr_o !== 32'h11 || if_id_pc_o !== 32'h0) begin n_err++; $display("FAIL rm_restart: got %h@%h expected 00000011@00000000", if_id_instr_o, if_id_pc_o); end
   endtask

   initial begin
      test_reset();
      test_straight_line();
      test_stall();
      test_flush_wait();
      test_flush_stall();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
